// File: rtl/bram_share_pkg.sv
// Shared constants, state encoding and bus-lane helper for the shared 512x8 block RAM controller.
package bram_share_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // In 512x8 mode the RAM carries data on the even lanes of its 16-bit bus.
    function automatic logic [15:0] spread8(input logic [7:0] b);
        logic [15:0] w;
        w = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            w[2*i] = b[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the port not granted last wins a tie.
module rr_arb2
    import bram_share_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic rr_last;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (rr_last == PORT_B) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last <= PORT_B;
        end else if (|gnt) begin
            rr_last <= gnt[1] ? PORT_B : PORT_A;
        end
    end

endmodule

// File: rtl/sb_ram40_4k.sv
// Behavioural model of the iCE40 SB_RAM40_4K primitive, 512x8 mode only (READ_MODE = WRITE_MODE = 1).
module SB_RAM40_4K #(
    parameter int READ_MODE  = 0,
    parameter int WRITE_MODE = 0
) (
    output logic [15:0] RDATA,
    input  logic [10:0] RADDR,
    input  logic        RCLK,
    input  logic        RCLKE,
    input  logic        RE,
    input  logic [10:0] WADDR,
    input  logic        WCLK,
    input  logic        WCLKE,
    input  logic        WE,
    input  logic [15:0] WDATA,
    input  logic [15:0] MASK
);

    localparam bit MODE_OK = (READ_MODE == 1) && (WRITE_MODE == 1);

    logic [7:0] mem [0:511];
    logic [7:0] rd_q;
    logic [7:0] wbyte;
    logic       unused_bits;

    assign wbyte = {WDATA[14], WDATA[12], WDATA[10], WDATA[8],
                    WDATA[6],  WDATA[4],  WDATA[2],  WDATA[0]};
    assign unused_bits = ^{RADDR[10:9], WADDR[10:9], MASK,
                           WDATA[15], WDATA[13], WDATA[11], WDATA[9],
                           WDATA[7],  WDATA[5],  WDATA[3],  WDATA[1]};

    always_ff @(posedge WCLK) begin
        if (MODE_OK && WCLKE && WE) begin
            mem[WADDR[8:0]] <= wbyte;
        end
    end

    always_ff @(posedge RCLK) begin
        if (RCLKE && RE) begin
            rd_q <= mem[RADDR[8:0]];
        end
    end

    assign RDATA = {1'b0, rd_q[7], 1'b0, rd_q[6], 1'b0, rd_q[5], 1'b0, rd_q[4],
                    1'b0, rd_q[3], 1'b0, rd_q[2], 1'b0, rd_q[1], 1'b0, rd_q[0]};

endmodule

// File: rtl/bram_share_ctrl.sv
// Two-port shared access to one SB_RAM40_4K (512x8) with an optional clear-after-reset sweep.
module bram_share_ctrl #(
    parameter int unsigned           ADDR_W         = bram_share_pkg::ADDR_W,
    parameter int unsigned           DATA_W         = bram_share_pkg::DATA_W,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0]     CLEAR_VALUE    = 8'h00
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy
);

    import bram_share_pkg::*;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [1:0]          gnt;
    logic                sel_b;
    logic                ram_we, ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wbyte;
    logic [15:0]         ram_rdata;
    logic [DATA_W-1:0]   ram_byte;
    logic [DATA_W-1:0]   a_hold_q, b_hold_q;
    logic                unused_rdata;

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    ({b_req, a_req}),
        .enable (state_q == ST_ARB),
        .gnt    (gnt)
    );

    assign a_gnt = gnt[PORT_A];
    assign b_gnt = gnt[PORT_B];
    assign sel_b = gnt[PORT_B];
    assign busy  = (state_q == ST_CLEAR) || !resetn;

    // Next state and RAM port drive: the clear sweep owns the RAM until ARB.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = sel_b ? b_addr : a_addr;
        ram_wbyte  = sel_b ? b_wdata : a_wdata;
        case (state_q)
            ST_CLEAR: begin
                ram_we     = 1'b1;
                ram_addr   = clr_addr_q;
                ram_wbyte  = CLEAR_VALUE;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (&clr_addr_q) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (|gnt) begin
                    ram_we = sel_b ? b_we : a_we;
                    ram_re = !(sel_b ? b_we : a_we);
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    SB_RAM40_4K #(
        .READ_MODE  (1),
        .WRITE_MODE (1)
    ) u_ram (
        .RDATA (ram_rdata),
        .RADDR (11'(ram_addr)),
        .RCLK  (clk),
        .RCLKE (1'b1),
        .RE    (ram_re),
        .WADDR (11'(ram_addr)),
        .WCLK  (clk),
        .WCLKE (1'b1),
        .WE    (ram_we),
        .WDATA (spread8(8'(ram_wbyte))),
        .MASK  (16'h0000)
    );

    assign ram_byte = DATA_W'({ram_rdata[14], ram_rdata[12], ram_rdata[10], ram_rdata[8],
                               ram_rdata[6],  ram_rdata[4],  ram_rdata[2],  ram_rdata[0]});
    assign unused_rdata = ^{ram_rdata[15], ram_rdata[13], ram_rdata[11], ram_rdata[9],
                            ram_rdata[7],  ram_rdata[5],  ram_rdata[3],  ram_rdata[1]};

    // RAM output is already registered; the hold registers keep it after other traffic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            a_rvalid <= gnt[PORT_A] & ~a_we;
            b_rvalid <= gnt[PORT_B] & ~b_we;
            if (a_rvalid) a_hold_q <= ram_byte;
            if (b_rvalid) b_hold_q <= ram_byte;
        end
    end

    assign a_rdata = a_rvalid ? ram_byte : a_hold_q;
    assign b_rdata = b_rvalid ? ram_byte : b_hold_q;

endmodule

// File: tb/tb_bram_share_ctrl.sv
// Directed bench for bram_share_ctrl: clear timing, arbitration order, read latency and reset recovery.
module tb_bram_share_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       a_req, a_we, b_req, b_we;
    logic [8:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
    logic [7:0] a_rdata, b_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bram_share_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single transaction on one port; expects entry just after a rising edge.
    task automatic xfer(input bit port, input bit we, input logic [8:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        #1;
        while (((port ? b_gnt : a_gnt) !== 1'b1) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_gnt"}, 32'(port ? b_gnt : a_gnt), 32'd1);
        @(posedge clk); #1;
        if (port) b_req = 1'b0; else a_req = 1'b0;
        check({tag, "_rvalid"}, 32'(port ? b_rvalid : a_rvalid), 32'(!we));
        if (!we) check({tag, "_rdata"}, 32'(port ? b_rdata : a_rdata), 32'(exp));
    endtask

    // Counts cycles until busy falls; also flags any grant seen meanwhile.
    task automatic wait_clear(input string tag);
        int  cnt;
        logic seen;
        cnt  = 0;
        seen = 1'b0;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (busy) seen = seen | a_gnt | b_gnt;
        end while (busy && cnt < 600);
        check({tag, "_busy_cycles"}, 32'(cnt), 32'd512);
        check({tag, "_gnt_while_busy"}, 32'(seen), 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        #23;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'd0);

        // Interrupt the first sweep at clr_addr = 100; the restarted sweep must be full length.
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("mid_clear_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_clear_rst_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'd5;
        wait_clear("clear1");
        check("b_gnt_first_arb", 32'(b_gnt), 32'd1);
        check("a_gnt_first_arb", 32'(a_gnt), 32'd0);
        @(posedge clk); #1;
        b_req = 1'b0;
        check("b_early_rvalid", 32'(b_rvalid), 32'd1);
        check("b_early_rdata", 32'(b_rdata), 32'h00);

        xfer(1'b0, 1'b0, 9'h000, 8'h00, 8'h00, "rd0");
        xfer(1'b0, 1'b0, 9'h0FF, 8'h00, 8'h00, "rd255");
        xfer(1'b0, 1'b0, 9'h1FF, 8'h00, 8'h00, "rd511");
        @(posedge clk); #1;
        check("rvalid_one_cycle", 32'(a_rvalid), 32'd0);
        check("rdata_hold", 32'(a_rdata), 32'h00);

        xfer(1'b0, 1'b1, 9'h000, 8'h11, 8'h00, "wr0");
        xfer(1'b0, 1'b1, 9'h1FF, 8'hA5, 8'h00, "wr511");
        xfer(1'b1, 1'b0, 9'h000, 8'h00, 8'h11, "b_rd0");
        xfer(1'b1, 1'b0, 9'h1FF, 8'h00, 8'hA5, "b_rd511");

        // Write in cycle N, other port reads in N+1.
        xfer(1'b0, 1'b1, 9'h003, 8'h44, 8'h00, "raw_wr");
        xfer(1'b1, 1'b0, 9'h003, 8'h00, 8'h44, "raw_rd");

        // Continuous contention: last grant went to B, so A leads.
        a_we = 1'b0; a_addr = 9'h000; b_we = 1'b0; b_addr = 9'h1FF;
        a_req = 1'b1; b_req = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("cont_a_gnt", 32'(a_gnt), 32'((i % 2) == 0));
            check("cont_b_gnt", 32'(b_gnt), 32'((i % 2) == 1));
            check("cont_excl", 32'(a_gnt & b_gnt), 32'd0);
            if (i > 0) check("cont_a_rvalid", 32'(a_rvalid), 32'(((i - 1) % 2) == 0));
            if (i % 2 == 1) check("cont_a_rdata", 32'(a_rdata), 32'h11);
            @(posedge clk); #1;
        end
        a_req = 1'b0; b_req = 1'b0;
        check("cont_last_b_rvalid", 32'(b_rvalid), 32'd1);
        check("cont_last_b_rdata", 32'(b_rdata), 32'hA5);

        // Reset right after a read grant removes the pending valid.
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h000;
        #1;
        check("arb_rst_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b0;
        a_req = 1'b0;
        #1;
        check("arb_rst_rvalid", 32'(a_rvalid), 32'd0);
        check("arb_rst_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_clear("clear2");
        xfer(1'b0, 1'b0, 9'h000, 8'h00, 8'h00, "post_clear_rd0");
        xfer(1'b1, 1'b0, 9'h003, 8'h00, 8'h00, "post_clear_rd3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
